hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Read-after-write hazard scheduler for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB). The register file has no internal bypass and the pipeline has no forwarding. This block tracks the destination registers of instructions in flight and compares them with the source registers of the instruction in ID. On a conflict it holds PC and IF/ID and injects a bubble into the ID/EX control register. It also freezes the whole pipeline when the external data bus requests wait states.

## Interface
Parameters:
- DEPTH, 3, scoreboard stages between ID and register-file write (EX, MEM, WB).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock (clk_sys domain).
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction (0 after reset/bubble).
- id_a_reg  in  5  source register A of ID instruction.
- id_b_reg  in  5  source register B of ID instruction.
- id_a_used / id_b_used  in  1 each  source actually read (imm forms clear b_used).
- id_wb_en  in  1  ID instruction writes back (write_back_en field of ctrl word).
- id_wb_reg  in  5  ID destination register (write_back_reg field).
- bus_wait  in  1  external bus not ready; freeze all pipeline registers.
- stall  out  1  hold PC and IF/ID register.
- bubble  out  1  load zero control word into CTRL_EX (A_EX/B_EX/IMM don't-care).
- freeze  out  1  hold every pipeline register, PC included.
- stall_count  out  CNT_W  saturating count of bubble cycles since reset.
- hazard_stage  out  2  stage of youngest conflicting producer: 0 none, 1 EX, 2 MEM, 3 WB.

## Operation
- Scoreboard: DEPTH entries {valid, reg[4:0]}, index 0 = EX, DEPTH-1 = WB.
- Hazard condition: for any entry with valid=1, reg≠0, and reg equal to a used source (id_a_reg & id_a_used, or id_b_reg & id_b_used), with id_valid=1.
- hazard_stage reports the lowest-index matching entry.
- Register 0 never causes a hazard, either as source or as destination.
- stall = bubble = hazard & !bus_wait.
- freeze = bus_wait.
- Freeze dominates: during freeze, stall=bubble=0, and neither the scoreboard nor the counter changes.
- Scoreboard update on each edge, when not frozen:
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= bubble ? invalid : {id_valid & id_wb_en, id_wb_reg}.
- stall_count increments on each edge with bubble=1 and saturates at all-ones.
- An instruction that is both source and destination of the same register (e.g. r5 <= r5+r1) compares sources only against older entries, never against itself.

## Timing
- stall, bubble, freeze and hazard_stage are combinational from the scoreboard and ID inputs, valid in the same cycle. No registered outputs except stall_count.
- Reset (rst=0): all entries invalid, stall_count=0. All outputs 0 except freeze, which follows bus_wait.
- Reset mid-stall clears the scoreboard immediately. The stalled instruction is released on the first cycle after reset.
- Bubble cycles for a dependent instruction, by producer distance:
  - immediately behind (producer in EX): 3.
  - 2 behind: 2.
  - 3 behind: 1.
  - 4 or more: 0.
- Maximum consecutive stall is DEPTH cycles unless bus_wait intervenes; bus_wait extends it without adding to stall_count.
- Simultaneous hazard and bus_wait: freeze only. The hazard is re-evaluated after bus_wait drops.
- WB writes at the same edge that retires entry[DEPTH-1], so ID reads the new value in the following cycle.

## Structure
- Shared package cpu_pkg:
  - REG_W=5.
  - CTRL_W=12.
  - field offsets of the ctrl word: c_sel[11], d_sel[10], op_sel[9:8], wr_rd[7], wb_sel[6], write_back_en[5], write_back_reg[4:0].
  - hazard_stage encodings.
- Sub-module: hazard_scoreboard (DEPTH-entry shift register with freeze/insert-invalid and parallel match outputs). The top level holds the priority encoder, the output logic and the saturating counter.
- Top-level CPU integration: PC and IF/ID take hold = stall | freeze; EX/MEM/WB registers take hold = freeze; CTRL_EX takes clear = bubble.

## Test plan
- Back-to-back dependency: add r3 (wb_en=1, wb_reg=3) followed by a reader of a_reg=3 (a_used=1) → stall=bubble=1 for 3 cycles with hazard_stage 1, 2, 3; stall_count=3.
- Independent and register-0 cases: producer writes r0, then a reader of r0; separately, reader b_reg=7 with b_used=0 against an in-flight r7 → stall never asserted, stall_count=0.
- Distance 3: r4 producer, two unrelated instructions, then a reader of r4 → exactly 1 bubble, hazard_stage=3.
- Freeze priority: hazard on r2 in EX with bus_wait=1 for 4 cycles → freeze=1, stall=0, scoreboard and stall_count unchanged. After bus_wait drops, 3 bubbles follow.
- Reset mid-stall: drive rst=0 during the second bubble cycle → all outputs 0 asynchronously. After release, id_valid=1 with a_reg=3 produces no stall.
- Saturation: CNT_W=4, force 20 hazard cycles → stall_count holds 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register/control-word geometry and the
// hazard stage encoding reported by the hazard scheduler.
package cpu_pkg;

   localparam int REG_W  = 5;
   localparam int CTRL_W = 12;

   // Control word field positions (CTRL_EX register)
   localparam int CTRL_C_SEL      = 11;
   localparam int CTRL_D_SEL      = 10;
   localparam int CTRL_OP_SEL_MSB = 9;
   localparam int CTRL_OP_SEL_LSB = 8;
   localparam int CTRL_WR_RD      = 7;
   localparam int CTRL_WB_SEL     = 6;
   localparam int CTRL_WB_EN      = 5;
   localparam int CTRL_WB_REG_MSB = 4;
   localparam int CTRL_WB_REG_LSB = 0;

   typedef enum logic [1:0] {
      HZ_NONE = 2'd0,
      HZ_EX   = 2'd1,
      HZ_MEM  = 2'd2,
      HZ_WB   = 2'd3
   } hz_stage_e;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } sb_entry_t;

   // Scoreboard index to reported stage; anything past MEM reports WB.
   function automatic hz_stage_e stage_of(input int idx);
      case (idx)
         0:       return HZ_EX;
         1:       return HZ_MEM;
         default: return HZ_WB;
      endcase
   endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage operand/destination bundle plus scheduler control outputs.
// master = pipeline side driving ID info, slave = hazard scheduler.
interface hazard_scheduler_if #(
   parameter int CNT_W = 16
);
   import cpu_pkg::*;

   logic                 id_valid;
   logic [REG_W-1:0]     id_a_reg;
   logic [REG_W-1:0]     id_b_reg;
   logic                 id_a_used;
   logic                 id_b_used;
   logic                 id_wb_en;
   logic [REG_W-1:0]     id_wb_reg;
   logic                 bus_wait;

   logic                 stall;
   logic                 bubble;
   logic                 freeze;
   logic [CNT_W-1:0]     stall_count;
   hz_stage_e            hazard_stage;

   modport master (
      output id_valid, id_a_reg, id_b_reg, id_a_used, id_b_used,
             id_wb_en, id_wb_reg, bus_wait,
      input  stall, bubble, freeze, stall_count, hazard_stage
   );

   modport slave (
      input  id_valid, id_a_reg, id_b_reg, id_a_used, id_b_used,
             id_wb_en, id_wb_reg, bus_wait,
      output stall, bubble, freeze, stall_count, hazard_stage
   );

endinterface

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers (index 0 = EX) with
// per-entry match flags against the ID instruction's used sources.
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_freeze,
   input  logic             i_bubble,
   input  logic             i_wb_valid,
   input  logic [REG_W-1:0] i_wb_reg,
   input  logic [REG_W-1:0] i_a_reg,
   input  logic             i_a_used,
   input  logic [REG_W-1:0] i_b_reg,
   input  logic             i_b_used,
   output logic [DEPTH-1:0] o_match
);

   sb_entry_t r_entry [DEPTH];

   // NOTE: these entries are plain flops, not a RAM, so every one is reset;
   // a stale valid bit left over from before reset would cause a false stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= '0;
         end
      end else if (!i_freeze) begin
         // NOTE: non-blocking assignments let every entry shift from its old value.
         r_entry[0] <= i_bubble ? '0 : '{valid: i_wb_valid, rd: i_wb_reg};
         for (int i = 1; i < DEPTH; i++) begin
            r_entry[i] <= r_entry[i-1];
         end
      end
   end

   // r0 is hardwired, so a write to it can never be a producer
   always_comb begin
      // NOTE: default assignment first keeps this purely combinational (no latch).
      o_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_match[i] = r_entry[i].valid && (r_entry[i].rd != '0) &&
                      ((i_a_used && (r_entry[i].rd == i_a_reg)) ||
                       (i_b_used && (r_entry[i].rd == i_b_reg)));
      end
   end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW hazard scheduler for a non-forwarding 5-stage pipeline: stalls ID on a
// conflict with an in-flight producer and freezes everything on bus wait.
module hazard_scheduler
   import cpu_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scheduler_if.slave  hs
);

   logic [DEPTH-1:0] w_match;
   logic             w_hazard;
   logic             w_bubble;
   hz_stage_e        w_stage;
   logic [CNT_W-1:0] r_stall_count;

   // The ID instruction itself is not in the scoreboard yet, so a
   // self-referencing instruction only ever compares against older producers.
   hazard_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_freeze   (hs.bus_wait),
      .i_bubble   (w_bubble),
      .i_wb_valid (hs.id_valid & hs.id_wb_en),
      .i_wb_reg   (hs.id_wb_reg),
      .i_a_reg    (hs.id_a_reg),
      .i_a_used   (hs.id_a_used),
      .i_b_reg    (hs.id_b_reg),
      .i_b_used   (hs.id_b_used),
      .o_match    (w_match)
   );

   // Walk oldest to youngest so the youngest producer wins
   always_comb begin
      w_stage = HZ_NONE;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_stage = stage_of(i);
         end
      end
   end

   assign w_hazard = hs.id_valid & (|w_match);
   assign w_bubble = w_hazard & ~hs.bus_wait;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_count <= '0;
      end else if (w_bubble && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign hs.stall        = w_bubble;
   assign hs.bubble       = w_bubble;
   assign hs.freeze       = hs.bus_wait;
   assign hs.stall_count  = r_stall_count;
   assign hs.hazard_stage = hs.id_valid ? w_stage : HZ_NONE;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench: directed test-plan scenarios plus random instruction
// streams against a queue-based model of in-flight producers.
module tb_hazard_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_scheduler_if #(.CNT_W(16)) if0 ();
   hazard_scheduler_if #(.CNT_W(4))  if1 ();

   hazard_scheduler #(.DEPTH(3), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .hs(if0));
   hazard_scheduler #(.DEPTH(3), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .hs(if1));

   int n_checks = 0;
   int n_errors = 0;

   // Model state: destinations of the three instructions ahead of ID
   // (front = oldest-issued last = EX); 0 means "writes nothing that matters".
   logic [4:0] q[$];
   int         cnt16;
   int         cnt4;

   logic       cur_valid, cur_au, cur_bu, cur_wben, cur_bw;
   logic [4:0] cur_a, cur_b, cur_wbreg;

   bit         e_bub;
   logic       o_stall;
   logic [1:0] o_stage;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] a, input logic au,
                         input logic [4:0] b, input logic bu,
                         input logic wben, input logic [4:0] wbreg);
      cur_valid = v;  cur_a = a; cur_au = au; cur_b = b; cur_bu = bu;
      cur_wben = wben; cur_wbreg = wbreg;
      if0.id_valid = v; if0.id_a_reg = a; if0.id_a_used = au;
      if0.id_b_reg = b; if0.id_b_used = bu; if0.id_wb_en = wben; if0.id_wb_reg = wbreg;
      if1.id_valid = v; if1.id_a_reg = a; if1.id_a_used = au;
      if1.id_b_reg = b; if1.id_b_used = bu; if1.id_wb_en = wben; if1.id_wb_reg = wbreg;
   endtask

   task automatic set_bw(input logic bw);
      cur_bw = bw;
      if0.bus_wait = bw;
      if1.bus_wait = bw;
   endtask

   task automatic model_reset();
      q = '{5'd0, 5'd0, 5'd0};
      cnt16 = 0;
      cnt4  = 0;
   endtask

   // Distance-based rule: the youngest producer of a read register decides.
   function automatic int exp_stage();
      if (!cur_valid) return 0;
      for (int i = 0; i < 3; i++) begin
         if (q[i] != 5'd0 && ((cur_au && q[i] == cur_a) || (cur_bu && q[i] == cur_b)))
            return i + 1;
      end
      return 0;
   endfunction

   // One clock: compare at negedge, advance the model at posedge.
   task automatic tick(output bit exp_bub, output logic obs_stall, output logic [1:0] obs_stage);
      int stg;
      @(negedge clk);
      stg = exp_stage();
      exp_bub = (stg != 0) && !cur_bw;
      obs_stall = if0.stall;
      obs_stage = if0.hazard_stage;
      check("stall",   32'(if0.stall),  32'(exp_bub));
      check("bubble",  32'(if0.bubble), 32'(exp_bub));
      check("freeze",  32'(if0.freeze), 32'(cur_bw));
      check("count16", 32'(if0.stall_count), 32'(cnt16));
      check("count4",  32'(if1.stall_count), 32'(cnt4));
      check("stall4",  32'(if1.stall),  32'(exp_bub));
      if (!cur_bw) check("stage", 32'(if0.hazard_stage), 32'(stg));
      @(posedge clk);
      if (!cur_bw) begin
         q.push_front(exp_bub ? 5'd0 : ((cur_valid && cur_wben) ? cur_wbreg : 5'd0));
         void'(q.pop_back());
         if (exp_bub) begin
            cnt16 = (cnt16 == 65535) ? 65535 : cnt16 + 1;
            cnt4  = (cnt4 == 15) ? 15 : cnt4 + 1;
         end
      end
      #1;
   endtask

   task automatic nop();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      tick(e_bub, o_stall, o_stage);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) nop();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int saved;
      int nb;
      bit hold;
      model_reset();
      set_bw(1'b0);
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      #12;
      // Reset state; freeze follows bus_wait even in reset
      check("rst_stall", 32'(if0.stall), 32'd0);
      check("rst_count", 32'(if0.stall_count), 32'd0);
      check("rst_stage", 32'(if0.hazard_stage), 32'd0);
      set_bw(1'b1);
      #1 check("rst_freeze", 32'(if0.freeze), 32'd1);
      set_bw(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Register 0 and unused-source cases
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
      tick(e_bub, o_stall, o_stage);
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd5);
      tick(e_bub, o_stall, o_stage);
      check("r0_stall", 32'(o_stall), 32'd0);
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7);
      tick(e_bub, o_stall, o_stage);
      set_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 1'b1, 5'd6);
      tick(e_bub, o_stall, o_stage);
      check("bunused_stall", 32'(o_stall), 32'd0);
      check("indep_count", 32'(if0.stall_count), 32'd0);
      flush();

      // Back-to-back dependency: 3 bubbles reporting EX, MEM, WB
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
      tick(e_bub, o_stall, o_stage);
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9);
      tick(e_bub, o_stall, o_stage);
      check("b2b_stage1", 32'(o_stage), 32'd1);
      tick(e_bub, o_stall, o_stage);
      check("b2b_stage2", 32'(o_stage), 32'd2);
      tick(e_bub, o_stall, o_stage);
      check("b2b_stage3", 32'(o_stage), 32'd3);
      tick(e_bub, o_stall, o_stage);
      check("b2b_release", 32'(o_stall), 32'd0);
      check("b2b_count", 32'(if0.stall_count), 32'd3);
      flush();

      // Distance 3: exactly one bubble
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4);
      tick(e_bub, o_stall, o_stage);
      nop();
      nop();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8);
      tick(e_bub, o_stall, o_stage);
      check("d3_stage", 32'(o_stage), 32'd3);
      check("d3_stall", 32'(o_stall), 32'd1);
      tick(e_bub, o_stall, o_stage);
      check("d3_release", 32'(o_stall), 32'd0);
      check("d3_count", 32'(if0.stall_count), 32'd4);
      flush();

      // Freeze dominates a live hazard, then 3 bubbles after it drops
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2);
      tick(e_bub, o_stall, o_stage);
      set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
      set_bw(1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(e_bub, o_stall, o_stage);
         check("frz_stall", 32'(o_stall), 32'd0);
      end
      check("frz_count", 32'(if0.stall_count), 32'd4);
      set_bw(1'b0);
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         tick(e_bub, o_stall, o_stage);
         if (o_stall) nb++;
      end
      check("frz_bubbles", 32'(nb), 32'd3);
      flush();

      // Reset during the second bubble cycle
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3);
      tick(e_bub, o_stall, o_stage);
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10);
      tick(e_bub, o_stall, o_stage);
      check("rms_first", 32'(o_stall), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rms_stall", 32'(if0.stall), 32'd0);
      check("rms_bubble", 32'(if0.bubble), 32'd0);
      check("rms_stage", 32'(if0.hazard_stage), 32'd0);
      check("rms_count", 32'(if0.stall_count), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      tick(e_bub, o_stall, o_stage);
      check("rms_release", 32'(o_stall), 32'd0);
      flush();

      // Saturation: chain of r2 <= f(r2) gives 7*3 = 21 bubbles
      saved = 0;
      for (int k = 0; k < 8; k++) begin
         set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2);
         for (int g = 0; g < 10; g++) begin
            tick(e_bub, o_stall, o_stage);
            if (!e_bub) break;
         end
      end
      check("sat_count16", 32'(if0.stall_count), 32'd21);
      check("sat_count4",  32'(if1.stall_count), 32'd15);
      flush();

      // Random instruction stream with occasional bus wait states
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            set_id(($urandom_range(0, 5) != 0),
                   5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 7)));
         end
         set_bw($urandom_range(0, 7) == 0);
         tick(e_bub, o_stall, o_stage);
         hold = e_bub || cur_bw;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
